// File: rtl/period_pkg.sv
// Shared types and constants for the period averaging stage.
package period_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        ACC,
        TMO
    } pavg_state_t;

endpackage

// File: rtl/period_averager_if.sv
// Sample input and block-result bundle between the frequency counter and the averager.
interface period_averager_if
    import period_pkg::*;
#(
    parameter int unsigned LOG2_N = 3
) ();

    logic             i_vld;
    logic [CNT_W-1:0] i_cnt;
    logic             o_vld;
    logic [CNT_W-1:0] o_avg;
    logic [CNT_W-1:0] o_min;
    logic [CNT_W-1:0] o_max;
    logic             o_timeout;
    logic [LOG2_N:0]  o_fill;

    modport master (
        output i_vld, i_cnt,
        input  o_vld, o_avg, o_min, o_max, o_timeout, o_fill
    );

    modport slave (
        input  i_vld, i_cnt,
        output o_vld, o_avg, o_min, o_max, o_timeout, o_fill
    );

endinterface

// File: rtl/period_timeout_timer.sv
// Saturating idle-cycle counter; flags expiry on the cycle its count reaches TIMEOUT_CYC.
module period_timeout_timer #(
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned  W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);
    localparam logic [W-1:0] LAST  = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry is reported while the current cycle brings the count to the limit.
    assign expired = run && (cnt_q >= LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/period_averager.sv
// Block averager for period samples: mean/min/max per 2**LOG2_N samples, with input-loss timeout.
module period_averager
    import period_pkg::*;
#(
    parameter int unsigned LOG2_N      = 3,
    parameter int unsigned TIMEOUT_CYC = 65536
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    period_averager_if.slave   bus
);

    localparam int unsigned N      = 1 << LOG2_N;
    localparam int unsigned ACC_W  = CNT_W + LOG2_N;
    localparam int unsigned FILL_W = LOG2_N + 1;

    pavg_state_t       state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  min_q, min_d;
    logic [CNT_W-1:0]  max_q, max_d;
    logic [CNT_W-1:0]  avg_q, avg_d;
    logic [CNT_W-1:0]  omin_q, omin_d;
    logic [CNT_W-1:0]  omax_q, omax_d;
    logic              vld_q, vld_d;
    logic              tmo_q, tmo_d;

    logic              accept;
    logic              last;
    logic              first;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  new_min;
    logic [CNT_W-1:0]  new_max;
    logic              tmr_clr;
    logic              tmr_run;
    logic              expired;

    assign accept  = en && bus.i_vld;
    assign tmr_clr = !en || accept || (state_q == IDLE);
    assign tmr_run = !tmr_clr;

    period_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .run     (tmr_run),
        .expired (expired)
    );

    always_comb begin
        last    = (fill_q == FILL_W'(N - 1));
        first   = (fill_q == '0);
        acc_sum = acc_q + ACC_W'(bus.i_cnt);
        new_min = (first || (bus.i_cnt < min_q)) ? bus.i_cnt : min_q;
        new_max = (first || (bus.i_cnt > max_q)) ? bus.i_cnt : max_q;

        state_d = state_q;
        acc_d   = acc_q;
        fill_d  = fill_q;
        min_d   = min_q;
        max_d   = max_q;
        avg_d   = avg_q;
        omin_d  = omin_q;
        omax_d  = omax_q;
        vld_d   = 1'b0;
        tmo_d   = tmo_q;

        if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
            fill_d  = '0;
            min_d   = '0;
            max_d   = '0;
            tmo_d   = 1'b0;
        end else if (accept) begin
            // Acceptance is en&i_vld in every state, including the IDLE exit cycle.
            tmo_d = 1'b0;
            if (last) begin
                state_d = FIRST;
                vld_d   = 1'b1;
                avg_d   = acc_sum[LOG2_N +: CNT_W];
                omin_d  = new_min;
                omax_d  = new_max;
                acc_d   = '0;
                fill_d  = '0;
                min_d   = '0;
                max_d   = '0;
            end else begin
                state_d = ACC;
                acc_d   = acc_sum;
                fill_d  = fill_q + 1'b1;
                min_d   = new_min;
                max_d   = new_max;
            end
        end else if (state_q == IDLE) begin
            state_d = FIRST;
        end else if (expired) begin
            state_d = TMO;
            tmo_d   = 1'b1;
            acc_d   = '0;
            fill_d  = '0;
            min_d   = '0;
            max_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            avg_q   <= '0;
            omin_q  <= '0;
            omax_q  <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
            min_q   <= min_d;
            max_q   <= max_d;
            avg_q   <= avg_d;
            omin_q  <= omin_d;
            omax_q  <= omax_d;
            vld_q   <= vld_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.o_vld     = vld_q;
    assign bus.o_avg     = avg_q;
    assign bus.o_min     = omin_q;
    assign bus.o_max     = omax_q;
    assign bus.o_timeout = tmo_q;
    assign bus.o_fill    = fill_q;

endmodule
